alu_sequencer: RTL and testbench

Micro-sequencer that drives the accumulator/ALU datapath. It accepts one arithmetic/logic instruction from the instruction decoder and steps through the register-load and execute strobes that the datapath samples. It captures the ALU status outputs into the 8085 flag register. It sits between the decoder and the ALU-plus-register datapath, and is the producer of that datapath's control interface.

---
 rtl/alu_seq_pkg.sv | 55 +++++
 rtl/alu_flag_reg.sv | 52 +++++
 rtl/alu_sequencer.sv | 123 ++++++++++++
 tb/tb_alu_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - encodings shared by the ALU micro-sequencer
// Holds the op_fn and state enums, the per-function ALU select words,
// the flag bit positions and the flag register reset value.
package alu_seq_pkg;

    // 8085 arithmetic/logic group, opcode bits 5:3
    typedef enum logic [2:0] {
        FN_ADD = 3'd0,
        FN_ADC = 3'd1,
        FN_SUB = 3'd2,
        FN_SBB = 3'd3,
        FN_ANA = 3'd4,
        FN_XRA = 3'd5,
        FN_ORA = 3'd6,
        FN_CMP = 3'd7
    } alu_fn_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_TMP  = 2'd2,
        ST_EXEC = 2'd3
    } seq_state_e;

    // Select word per function: {op1, op2, neg, ncarry_1, shift_right}.
    // Bit 0 is always 0 here; shifting is reserved for rotate extensions.
    localparam logic [4:0] CW [8] = '{
        5'b10000,   // ADD
        5'b10000,   // ADC
        5'b10100,   // SUB
        5'b10100,   // SBB
        5'b01000,   // ANA
        5'b11000,   // XRA
        5'b01010,   // ORA
        5'b10100    // CMP
    };

    // Flag layout: S Z 0 AC 0 P 1 CY
    localparam int unsigned FLAG_S  = 7;
    localparam int unsigned FLAG_Z  = 6;
    localparam int unsigned FLAG_AC = 4;
    localparam int unsigned FLAG_P  = 2;
    localparam int unsigned FLAG_CY = 0;

    localparam logic [7:0] FLAGS_RESET = 8'h02;

    function automatic logic is_add_fn(alu_fn_e fn);
        return (fn == FN_ADD) || (fn == FN_ADC);
    endfunction

    function automatic logic is_sub_fn(alu_fn_e fn);
        return (fn == FN_SUB) || (fn == FN_SBB) || (fn == FN_CMP);
    endfunction

endpackage

// File: rtl/alu_flag_reg.sv
// rtl/alu_flag_reg.sv - 8085 flag register with flag compute logic
// Ports: clk, rst_n (async, active-low); we loads new flags at the next
// posedge; fn selects add/sub/logic carry semantics; alu_sign/zero/parity/
// aux/carry_n are the ALU status inputs; flags is the registered S Z 0 AC 0 P 1 CY.
module alu_flag_reg
    import alu_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       we,
    input  alu_fn_e    fn,
    input  logic       alu_sign,
    input  logic       alu_zero,
    input  logic       alu_parity,
    input  logic       alu_aux,
    input  logic       alu_carry_n,
    output logic [7:0] flags
);

    logic [7:0] flags_q;
    logic [7:0] flags_d;

    always_comb begin
        flags_d = flags_q;
        if (we) begin
            // Start from the constant bits, then fill the live ones.
            flags_d          = FLAGS_RESET;
            flags_d[FLAG_S]  = alu_sign;
            flags_d[FLAG_Z]  = alu_zero;
            flags_d[FLAG_P]  = ~alu_parity;
            if (is_add_fn(fn)) begin
                flags_d[FLAG_CY] = ~alu_carry_n;
                flags_d[FLAG_AC] = alu_aux;
            end else if (is_sub_fn(fn)) begin
                // Active-low carry-out of a + ~b + 1 is the borrow.
                flags_d[FLAG_CY] = alu_carry_n;
                flags_d[FLAG_AC] = alu_aux;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= FLAGS_RESET;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign flags = flags_q;

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - micro-sequencer for the accumulator/ALU datapath
// Ports: clk, rst_n (async, active-low); op_valid/op_ready/op_fn instruction
// handshake; operand_valid marks the operand on the data bus; alu_* are ALU
// status inputs; select_*/shift_right_in/alu_cin_n drive the ALU function;
// a_to_act .. fe_0_to_act are datapath register strobes; flags is the 8085
// flag register; done pulses for one cycle when an instruction retires.
module alu_sequencer
    import alu_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       op_valid,
    output logic       op_ready,
    input  logic [2:0] op_fn,
    input  logic       operand_valid,
    input  logic [7:0] alu_result,
    input  logic       alu_zero,
    input  logic       alu_parity,
    input  logic       alu_aux,
    input  logic       alu_carry_n,
    output logic       select_op1,
    output logic       select_op2,
    output logic       select_neg,
    output logic       select_ncarry_1,
    output logic       select_shift_right,
    output logic       shift_right_in,
    output logic       alu_cin_n,
    output logic       a_to_act,
    output logic       dbus_to_act,
    output logic       write_dbus_to_alu_tmp,
    output logic       alu_to_a,
    output logic       sel_alu_a,
    output logic       alu_a_to_dbus,
    output logic       sel_0_fe,
    output logic       fe_0_to_act,
    output logic [7:0] flags,
    output logic       done
);

    seq_state_e state_q, state_d;
    alu_fn_e    fn_q;

    // State register and latched function
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            fn_q    <= FN_ADD;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && op_valid) begin
                fn_q <= alu_fn_e'(op_fn);
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (op_valid) state_d = ST_ACC;
            ST_ACC:  state_d = ST_TMP;
            ST_TMP:  if (operand_valid) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Moore outputs decoded from state; only the temp-register load
    // follows operand_valid directly.
    always_comb begin
        op_ready              = 1'b0;
        a_to_act              = 1'b0;
        write_dbus_to_alu_tmp = 1'b0;
        alu_to_a              = 1'b0;
        done                  = 1'b0;
        select_op1            = 1'b0;
        select_op2            = 1'b0;
        select_neg            = 1'b0;
        select_ncarry_1       = 1'b0;
        alu_cin_n             = 1'b1;
        unique case (state_q)
            ST_IDLE: op_ready = 1'b1;
            ST_ACC:  a_to_act = 1'b1;
            ST_TMP:  write_dbus_to_alu_tmp = operand_valid;
            ST_EXEC: begin
                {select_op1, select_op2, select_neg, select_ncarry_1} = CW[fn_q][4:1];
                alu_to_a = (fn_q != FN_CMP);
                done     = 1'b1;
                // Carry chains read the CY value held before this instruction.
                unique case (fn_q)
                    FN_ADC:         alu_cin_n = ~flags[FLAG_CY];
                    FN_SUB, FN_CMP: alu_cin_n = 1'b0;
                    FN_SBB:         alu_cin_n = flags[FLAG_CY];
                    default:        alu_cin_n = 1'b1;
                endcase
            end
            default: op_ready = 1'b0;
        endcase
    end

    // Reserved for increment/rotate extensions
    assign dbus_to_act        = 1'b0;
    assign sel_0_fe           = 1'b0;
    assign fe_0_to_act        = 1'b0;
    assign shift_right_in     = 1'b0;
    assign select_shift_right = 1'b0;
    assign sel_alu_a          = 1'b1;
    assign alu_a_to_dbus      = 1'b0;

    alu_flag_reg u_flag_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .we          (state_q == ST_EXEC),
        .fn          (fn_q),
        .alu_sign    (alu_result[7]),
        .alu_zero    (alu_zero),
        .alu_parity  (alu_parity),
        .alu_aux     (alu_aux),
        .alu_carry_n (alu_carry_n),
        .flags       (flags)
    );

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - self-checking bench for alu_sequencer
module tb_alu_sequencer;
    import alu_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       op_valid;
    logic       op_ready;
    logic [2:0] op_fn;
    logic       operand_valid;
    logic [7:0] alu_result;
    logic       alu_zero, alu_parity, alu_aux, alu_carry_n;
    logic       select_op1, select_op2, select_neg, select_ncarry_1, select_shift_right;
    logic       shift_right_in, alu_cin_n;
    logic       a_to_act, dbus_to_act, write_dbus_to_alu_tmp, alu_to_a;
    logic       sel_alu_a, alu_a_to_dbus, sel_0_fe, fe_0_to_act;
    logic [7:0] flags;
    logic       done;

    int passed = 0;
    int total  = 0;

    // Reference state: accumulator contents and flag register
    logic [7:0] acc_m;
    logic [7:0] flags_m;

    alu_sequencer dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .op_valid              (op_valid),
        .op_ready              (op_ready),
        .op_fn                 (op_fn),
        .operand_valid         (operand_valid),
        .alu_result            (alu_result),
        .alu_zero              (alu_zero),
        .alu_parity            (alu_parity),
        .alu_aux               (alu_aux),
        .alu_carry_n           (alu_carry_n),
        .select_op1            (select_op1),
        .select_op2            (select_op2),
        .select_neg            (select_neg),
        .select_ncarry_1       (select_ncarry_1),
        .select_shift_right    (select_shift_right),
        .shift_right_in        (shift_right_in),
        .alu_cin_n             (alu_cin_n),
        .a_to_act              (a_to_act),
        .dbus_to_act           (dbus_to_act),
        .write_dbus_to_alu_tmp (write_dbus_to_alu_tmp),
        .alu_to_a              (alu_to_a),
        .sel_alu_a             (sel_alu_a),
        .alu_a_to_dbus         (alu_a_to_dbus),
        .sel_0_fe              (sel_0_fe),
        .fe_0_to_act           (fe_0_to_act),
        .flags                 (flags),
        .done                  (done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] constant_strobes();
        return {dbus_to_act, sel_0_fe, fe_0_to_act, shift_right_in,
                select_shift_right, sel_alu_a, alu_a_to_dbus, 1'b0};
    endfunction

    // One instruction through the sequencer. The bench acts as the ALU:
    // it computes the arithmetic result from acc_m and the operand, then
    // derives the expected flags from the status it drives.
    // cn_force < 0 lets the model choose carry_n; otherwise it is forced.
    task automatic run_op(input logic [2:0] fn, input logic [7:0] operand,
                          input int stall, input int cn_force);
        logic [8:0] wide;
        logic [4:0] nib;
        logic [7:0] r;
        logic       cn, aux, cy_old, exp_cy, exp_ac, exp_cin;
        logic [4:0] exp_cw;
        logic [7:0] exp_flags;
        int         n;

        cy_old = flags_m[0];
        case (fn)
            3'd0, 3'd1: begin
                wide = {1'b0, acc_m} + {1'b0, operand} + ((fn == 3'd1) ? {8'd0, cy_old} : 9'd0);
                nib  = {1'b0, acc_m[3:0]} + {1'b0, operand[3:0]} + ((fn == 3'd1) ? {4'd0, cy_old} : 5'd0);
                r = wide[7:0]; cn = ~wide[8]; aux = nib[4];
            end
            3'd2, 3'd3, 3'd7: begin
                wide = {1'b0, acc_m} - {1'b0, operand} - ((fn == 3'd3) ? {8'd0, cy_old} : 9'd0);
                nib  = {1'b0, acc_m[3:0]} - {1'b0, operand[3:0]} - ((fn == 3'd3) ? {4'd0, cy_old} : 5'd0);
                r = wide[7:0]; cn = wide[8]; aux = nib[4];
            end
            3'd4: begin r = acc_m & operand; cn = 1'($urandom); aux = 1'($urandom); end
            3'd5: begin r = acc_m ^ operand; cn = 1'($urandom); aux = 1'($urandom); end
            default: begin r = acc_m | operand; cn = 1'($urandom); aux = 1'($urandom); end
        endcase
        if (cn_force >= 0) cn = (cn_force != 0);

        if (fn <= 3'd1) begin
            exp_cy = ~cn; exp_ac = aux; exp_cin = (fn == 3'd1) ? ~cy_old : 1'b1; exp_cw = 5'b10000;
        end else if (fn == 3'd2 || fn == 3'd3 || fn == 3'd7) begin
            exp_cy = cn; exp_ac = aux; exp_cin = (fn == 3'd3) ? cy_old : 1'b0; exp_cw = 5'b10100;
        end else begin
            exp_cy = 1'b0; exp_ac = 1'b0; exp_cin = 1'b1; exp_cw = CW[fn];
        end
        exp_flags = {r[7], (r == 8'd0), 1'b0, exp_ac, 1'b0, ~(^r), 1'b1, exp_cy};

        alu_result = r; alu_zero = (r == 8'd0); alu_parity = ^r;
        alu_aux = aux; alu_carry_n = cn;

        check("idle_op_ready", {7'd0, op_ready}, 8'd1);
        op_valid = 1'b1; op_fn = fn; operand_valid = 1'b0;
        step(); n = 1;
        op_valid = 1'b0;
        check("acc_strobes", {4'd0, a_to_act, op_ready, alu_to_a, alu_cin_n}, 8'b0000_1001);
        step(); n++;
        for (int i = 0; i < stall; i++) begin
            check("tmp_stall", {6'd0, write_dbus_to_alu_tmp, op_ready}, 8'd0);
            step(); n++;
        end
        operand_valid = 1'b1;
        #1;
        check("tmp_load", {6'd0, write_dbus_to_alu_tmp, done}, 8'b10);
        step(); n++;
        operand_valid = 1'b0;
        check("exec_done", {7'd0, done}, 8'd1);
        check("latency", 8'(n), 8'(3 + stall));
        check("exec_alu_to_a", {7'd0, alu_to_a}, {7'd0, (fn != 3'd7)});
        check("exec_cw", {3'd0, select_op1, select_op2, select_neg, select_ncarry_1, select_shift_right},
              {3'd0, exp_cw});
        check("exec_cin_n", {7'd0, alu_cin_n}, {7'd0, exp_cin});
        check("flags_hold", flags, flags_m);
        step();
        check("retire", {6'd0, done, op_ready}, 8'd1);
        check("flags_new", flags, exp_flags);
        check("const_strobes", constant_strobes(), 8'b0000_0100);
        flags_m = exp_flags;
        if (fn != 3'd7) acc_m = r;
    endtask

    initial begin
        rst_n = 1'b0; op_valid = 1'b0; op_fn = 3'd0; operand_valid = 1'b0;
        alu_result = 8'd0; alu_zero = 1'b0; alu_parity = 1'b0; alu_aux = 1'b0; alu_carry_n = 1'b1;
        acc_m = 8'h00; flags_m = 8'h02;
        repeat (3) step();
        check("rst_flags", flags, 8'h02);
        check("rst_ctrl", {op_ready, done, a_to_act, write_dbus_to_alu_tmp, alu_to_a, alu_cin_n, 2'b00},
              8'b1000_0100);
        rst_n = 1'b1;
        step();

        // ADD 0x3A + 0xC6 -> 0x00 with carry and half carry
        acc_m = 8'h3A;
        run_op(3'd0, 8'hC6, 0, -1);
        check("add_flags_57", flags, 8'h57);
        // ADC with CY=1 -> cin_n 0
        run_op(3'd1, 8'h05, 0, -1);
        // CMP with result 0 and forced carry_n=1 -> Z=1, CY=1, A untouched
        acc_m = 8'h06;
        run_op(3'd7, 8'h06, 0, 1);
        check("cmp_flags", flags & 8'h41, 8'h41);
        // SUB borrowing -> CY=1, then SBB uses cin_n=1
        run_op(3'd2, 8'h10, 0, -1);
        run_op(3'd3, 8'h01, 0, -1);
        // SBB with CY=0 -> cin_n=0
        run_op(3'd3, 8'h01, 0, -1);
        // Operand stall of 5 cycles
        run_op(3'd6, 8'h5A, 5, -1);

        // Back-to-back: op_valid held high, ORA with a zero result
        op_valid = 1'b1; op_fn = 3'd6; operand_valid = 1'b1;
        alu_result = 8'h00; alu_zero = 1'b1; alu_parity = 1'b0; alu_aux = 1'b1; alu_carry_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            check("b2b_ready", {7'd0, op_ready}, {7'd0, (k % 4 == 0)});
            check("b2b_done", {7'd0, done}, {7'd0, (k % 4 == 3)});
            step();
        end
        check("b2b_ready_end", {7'd0, op_ready}, 8'd1);
        op_valid = 1'b0; operand_valid = 1'b0;
        check("b2b_flags", flags, 8'h46);
        flags_m = 8'h46; acc_m = 8'h00;

        // Make the flags differ from reset, then reset in TMP
        acc_m = 8'hFF;
        run_op(3'd0, 8'h01, 0, -1);
        op_valid = 1'b1; op_fn = 3'd0;
        step(); op_valid = 1'b0;
        step();
        operand_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_flags", flags, 8'h02);
        check("midrst_ctrl", {op_ready, done, a_to_act, write_dbus_to_alu_tmp, alu_to_a, alu_cin_n, 2'b00},
              8'b1000_0100);
        operand_valid = 1'b0;
        #2 rst_n = 1'b1;
        step();
        flags_m = 8'h02;
        run_op(3'd5, 8'h3C, 1, -1);

        // Randomized instructions
        for (int t = 0; t < 30; t++) begin
            run_op(3'($urandom_range(0, 7)), 8'($urandom), $urandom_range(0, 3), -1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
